mul_div_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register-read operands (Read_data1 → rs1_data, Read_data2 → rs2_data) plus funct3 when the decoder flags an M-extension instruction.
- Stalls the pipeline via busy for a fixed latency.
- Returns a 32-bit result to the writeback path feeding the register file's Write_data.

---
 rtl/mul_div_unit.sv | 177 +++++++++++++++++
 tb/tb_mul_div_unit.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit.
// Multiplies use radix-2 shift-add and divides use restoring shift-subtract, both on operand
// magnitudes. A final cycle applies the sign correction and picks the output word. Every
// operation takes DATA_W iterations plus one fix-up cycle, whatever the operand values.
module mul_div_unit #(
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] rs1_data_i,
    input  logic [DATA_W-1:0] rs2_data_i,
    input  logic              flush_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o
);

    localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e                state_q;
    logic [2:0]            op_q;
    logic [CntW-1:0]       cnt_q;
    // Multiply: {partial product, multiplier}. Divide: {remainder, dividend/quotient}.
    logic [2*DATA_W-1:0]   acc_q;
    // Multiplicand (multiply) or divisor (divide) magnitude.
    logic [DATA_W-1:0]     opb_q;
    logic                  neg_q;      // product / quotient must be negated
    logic                  sign_a_q;   // dividend was negative (remainder sign)
    logic                  div0_q;     // divisor was zero
    logic                  busy_q;
    logic                  done_q;
    logic [DATA_W-1:0]     result_q;

    logic                  signed_a;
    logic                  signed_b;
    logic                  sign_a;
    logic                  sign_b;
    logic [DATA_W-1:0]     mag_a;
    logic [DATA_W-1:0]     mag_b;

    logic [DATA_W:0]       mul_sum;
    logic [2*DATA_W-1:0]   mul_next;
    logic [DATA_W:0]       div_shift;
    logic [DATA_W:0]       div_diff;
    logic [2*DATA_W-1:0]   div_next;

    logic [2*DATA_W-1:0]   prod_fix;
    logic [DATA_W-1:0]     quot_fix;
    logic [DATA_W-1:0]     rem_fix;
    logic [DATA_W-1:0]     fix_result;

    // Operand signedness per funct3 and magnitudes of the incoming operands.
    always_comb begin
        signed_a = 1'b0;
        signed_b = 1'b0;
        case (op_i)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                signed_a = 1'b1;
                signed_b = 1'b1;
            end
            3'b010: begin
                signed_a = 1'b1;
                signed_b = 1'b0;
            end
            default: begin
                signed_a = 1'b0;
                signed_b = 1'b0;
            end
        endcase
        sign_a = signed_a & rs1_data_i[DATA_W-1];
        sign_b = signed_b & rs2_data_i[DATA_W-1];
        mag_a  = sign_a ? -rs1_data_i : rs1_data_i;
        mag_b  = sign_b ? -rs2_data_i : rs2_data_i;
    end

    // One iteration of shift-add multiply and of restoring divide.
    always_comb begin
        mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
        mul_next  = {mul_sum, acc_q[DATA_W-1:1]};
        div_shift = {acc_q[2*DATA_W-1:DATA_W], acc_q[DATA_W-1]};
        div_diff  = div_shift - {1'b0, opb_q};
        // A set top bit means the trial subtraction went negative: restore.
        if (div_diff[DATA_W]) begin
            div_next = {div_shift[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b0};
        end else begin
            div_next = {div_diff[DATA_W-1:0], acc_q[DATA_W-2:0], 1'b1};
        end
    end

    // Sign correction and word selection for the fix-up cycle.
    always_comb begin
        prod_fix = neg_q ? -acc_q : acc_q;
        quot_fix = neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
        rem_fix  = sign_a_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
        case (op_q)
            3'b000:                 fix_result = prod_fix[DATA_W-1:0];
            3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*DATA_W-1:DATA_W];
            // Divide by zero returns all ones regardless of dividend sign; the remainder
            // path already yields the dividend in that case.
            3'b100, 3'b101:         fix_result = div0_q ? '1 : quot_fix;
            default:                fix_result = rem_fix;
        endcase
    end

    // Control FSM and datapath registers; reset and flush take priority over everything.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            op_q     <= '0;
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            sign_a_q <= 1'b0;
            div0_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start_i && !flush_i) begin
                        op_q     <= op_i;
                        cnt_q    <= '0;
                        neg_q    <= sign_a ^ sign_b;
                        sign_a_q <= sign_a;
                        div0_q   <= (rs2_data_i == '0);
                        if (op_i[2]) begin
                            acc_q <= {{DATA_W{1'b0}}, mag_a};
                            opb_q <= mag_b;
                        end else begin
                            acc_q <= {{DATA_W{1'b0}}, mag_b};
                            opb_q <= mag_a;
                        end
                        busy_q  <= 1'b1;
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    if (flush_i) begin
                        busy_q  <= 1'b0;
                        state_q <= StIdle;
                    end else begin
                        acc_q <= op_q[2] ? div_next : mul_next;
                        if (cnt_q == CntW'(DATA_W - 1)) begin
                            state_q <= StFix;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                end
                StFix: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                    if (!flush_i) begin
                        result_q <= fix_result;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign result_o = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: stimulus pushes expected results, a monitor checks them.
module tb_mul_div_unit;

    localparam int unsigned W = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = 3'b000;
    logic [W-1:0]  rs1 = '0;
    logic [W-1:0]  rs2 = '0;
    logic          flush = 1'b0;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;

    typedef struct {
        logic [W-1:0] res;
        int           t;
        string        name;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;

    mul_div_unit #(.DATA_W(W)) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .start_i    (start),
        .op_i       (op),
        .rs1_data_i (rs1),
        .rs2_data_i (rs2),
        .flush_i    (flush),
        .busy_o     (busy),
        .done_o     (done),
        .result_o   (result)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && done) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done with result %h at cycle %0d, expected none",
                         result, cyc);
            end else begin
                e = sb_q.pop_front();
                check(e.name, result, e.res);
                check({e.name, "_latency"}, cyc, e.t + W + 2);
            end
        end
    end

    // Call at a negedge with the DUT able to accept; returns at the negedge after acceptance.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string name, input bit push);
        exp_t e;
        start = 1'b1;
        op    = o;
        rs1   = a;
        rs2   = b;
        @(posedge clk);
        e.res  = exp;
        e.t    = cyc;
        e.name = name;
        if (push) sb_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        // Scramble operands: the DUT must not look at them after acceptance.
        op    = 3'b011;
        rs1   = 32'hDEAD_BEEF;
        rs2   = 32'h1234_5678;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle_timeout: got busy=1, expected busy=0 within 100 cycles");
        end
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_done_timeout: got done=0, expected done within 100 cycles");
        end
    endtask

    task automatic run(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name);
        wait_idle();
        issue(o, a, b, exp, name, 1'b1);
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no end of test, expected finish before 1 ms");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int bc;
        int n;

        // Reset state.
        repeat (3) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // MUL 7 * -3 with busy-window check.
        issue(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "mul_7_m3", 1'b1);
        check("accept_busy", busy, 1);
        bc = busy ? 1 : 0;
        n  = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (done) break;
            if (busy) bc++;
        end
        check("busy_cycles", bc, 33);
        check("busy_in_done", busy, 0);

        // High-word and low-word multiplies.
        run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mulhu_ff_ff");
        run(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, "mulh_ff_ff");
        run(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff_ff");
        run(3'b000, 32'h8000_0000, 32'd2, 32'h0000_0000, "mul_8000_2");
        run(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "mulh_min_min");

        // Divide and remainder, signed and unsigned.
        run(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "div_m7_2");
        run(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "rem_m7_2");
        run(3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, "divu_fff9_2");
        run(3'b111, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, "remu_fff9_2");
        run(3'b100, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, "div_100_m7");
        run(3'b110, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, "rem_100_m7");

        // Divide by zero and signed overflow.
        run(3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, "div_5_0");
        run(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF, "divu_5_0");
        run(3'b110, 32'd5, 32'd0, 32'h0000_0005, "rem_5_0");
        run(3'b111, 32'd5, 32'd0, 32'h0000_0005, "remu_5_0");
        run(3'b100, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, "div_m5_0");
        run(3'b110, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, "rem_m5_0");
        run(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf");
        run(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, "rem_ovf");

        // A start while busy is ignored.
        run(3'b101, 32'd100, 32'd7, 32'h0000_000E, "divu_100_7");
        repeat (3) @(negedge clk);
        start = 1'b1;
        op    = 3'b000;
        rs1   = 32'd5;
        rs2   = 32'd5;
        @(negedge clk);
        start = 1'b0;

        // Start in the done cycle is accepted back-to-back.
        wait_done();
        issue(3'b111, 32'd100, 32'd7, 32'h0000_0002, "remu_b2b", 1'b1);

        // Flush mid-operation: no done, result holds the previous value.
        wait_idle();
        issue(3'b000, 32'd9, 32'd9, 32'd81, "mul_flushed", 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_result_hold", result, 32'h0000_0002);
        repeat (40) @(negedge clk);

        // Flush wins over start in idle.
        flush = 1'b1;
        start = 1'b1;
        op    = 3'b000;
        rs1   = 32'd6;
        rs2   = 32'd6;
        @(negedge clk);
        flush = 1'b0;
        start = 1'b0;
        check("flush_start_busy", busy, 0);
        repeat (40) @(negedge clk);

        // Reset mid-operation clears everything with no done.
        issue(3'b000, 32'd9, 32'd9, 32'd81, "mul_reset", 1'b0);
        repeat (19) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midreset_busy", busy, 0);
        check("midreset_done", done, 0);
        check("midreset_result", result, 0);
        rst_n = 1'b1;

        run(3'b000, 32'd3, 32'd4, 32'd12, "mul_3_4");

        wait_idle();
        repeat (3) @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
